// File: rtl/sram_req_arb_pkg.sv
// Shared definitions for the SRAM-like request arbiter: requester tags and FSM encodings.
package sram_req_arb_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'b001,
        ARB_HOLD_I = 3'b010,
        ARB_HOLD_D = 3'b100
    } arb_state_e;

    // Bits needed to hold 0..lim, never less than one.
    function automatic int sat_cnt_width(input int lim);
        return (lim < 1) ? 1 : $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/arb_order_fifo.sv
// In-order 1-bit tag FIFO recording which requester owns each outstanding transaction.
module arb_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers rely on natural wrap because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_req_arb.sv
// Two-to-one SRAM-like request arbiter with grant lock, in-order response routing
// and bounded instruction-fetch priority.
module sram_req_arb
    import sram_req_arb_pkg::*;
#(
    parameter int OUTST      = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        resp_err
);

    localparam int SW = sat_cnt_width(STARVE_LIM);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          resp_err_q, resp_err_d;

    logic grant_i, grant_d, drive_en, accept, pop;
    logic full, empty, head;

    arb_order_fifo #(
        .DEPTH (OUTST)
    ) u_order_fifo (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .push_i  (accept),
        .din_i   (grant_d ? SRC_DATA : SRC_INST),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // A fresh grant needs room in the tracker; a held grant is never revoked.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (!full && data_req && !(inst_req && starve_q == SW'(STARVE_LIM))) begin
                    grant_d = 1'b1;
                end else if (!full && inst_req) begin
                    grant_i = 1'b1;
                end
            end
            ARB_HOLD_I: grant_i = 1'b1;
            ARB_HOLD_D: grant_d = 1'b1;
            default: ;
        endcase
    end

    assign drive_en = aresetn & (grant_i | grant_d);
    assign m_req    = aresetn & ((grant_i & inst_req) | (grant_d & data_req));
    assign m_wr     = drive_en & (grant_d ? data_wr : inst_wr);
    assign m_size   = {2{drive_en}}  & (grant_d ? data_size  : inst_size);
    assign m_addr   = {32{drive_en}} & (grant_d ? data_addr  : inst_addr);
    assign m_wstrb  = {4{drive_en}}  & (grant_d ? data_wstrb : inst_wstrb);
    assign m_wdata  = {32{drive_en}} & (grant_d ? data_wdata : inst_wdata);

    assign accept       = m_req & m_addr_ok;
    assign inst_addr_ok = accept & grant_i;
    assign data_addr_ok = accept & grant_d;

    assign pop          = m_data_ok & ~empty;
    assign inst_data_ok = pop & (head == SRC_INST);
    assign data_data_ok = pop & (head == SRC_DATA);
    assign inst_rdata   = (!empty && head == SRC_INST) ? m_rdata : '0;
    assign data_rdata   = (!empty && head == SRC_DATA) ? m_rdata : '0;
    assign resp_err     = resp_err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (m_req && !m_addr_ok) begin
                    state_d = grant_d ? ARB_HOLD_D : ARB_HOLD_I;
                end
            end
            ARB_HOLD_I, ARB_HOLD_D: begin
                if (!m_req || m_addr_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        starve_d = starve_q;
        if (accept && grant_d && inst_req) begin
            if (starve_q != SW'(STARVE_LIM)) begin
                starve_d = starve_q + SW'(1);
            end
        end else if (accept && grant_i) begin
            starve_d = '0;
        end

        resp_err_d = resp_err_q | (m_data_ok & empty);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ARB_IDLE;
            starve_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            resp_err_q <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arb.sv
// Directed bench for sram_req_arb: routing, grant lock, starvation bound, backpressure, errors.
module tb_sram_req_arb;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    sram_req_arb #(
        .OUTST      (4),
        .STARVE_LIM (3)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wstrb   (inst_wstrb),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wstrb      (m_wstrb),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata),
        .resp_err     (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge aclk);
    endtask

    task automatic to_next();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn   = 1'b0;
        inst_req  = 1'b1; inst_wr = 1'b0; inst_size = 2'd2;
        inst_addr = 32'h1C00_0000; inst_wstrb = 4'h0; inst_wdata = '0;
        data_req  = 1'b0; data_wr = 1'b0; data_size = 2'd2;
        data_addr = '0; data_wstrb = 4'h0; data_wdata = '0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;

        // Reset held with an active request: bridge side must stay quiet.
        to_next(); to_neg();
        chk("rst_m_req", 32'(m_req), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
        to_next();
        inst_req = 1'b0;
        aresetn  = 1'b1;
        to_next();

        // Single instruction read.
        inst_req = 1'b1;
        to_neg();
        chk("t1_m_req", 32'(m_req), 1);
        chk("t1_m_addr", m_addr, 32'h1C00_0000);
        chk("t1_addr_ok_early", 32'(inst_addr_ok), 0);
        to_next();
        m_addr_ok = 1'b1;
        to_neg();
        chk("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
        chk("t1_data_addr_ok", 32'(data_addr_ok), 0);
        to_next();
        inst_req = 1'b0; m_addr_ok = 1'b0;
        to_next(); to_next();
        m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
        to_neg();
        chk("t1_inst_data_ok", 32'(inst_data_ok), 1);
        chk("t1_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
        chk("t1_data_data_ok", 32'(data_data_ok), 0);
        chk("t1_data_rdata", data_rdata, 0);
        to_next();
        m_data_ok = 1'b0;

        // Simultaneous requests: data wins, inst follows, responses in order.
        inst_req = 1'b1; inst_addr = 32'h0000_0200;
        data_req = 1'b1; data_addr = 32'h0000_0100;
        data_wr = 1'b1; data_wstrb = 4'hF; data_wdata = 32'hCAFE_0001;
        m_addr_ok = 1'b1;
        to_neg();
        chk("t2_m_addr_d", m_addr, 32'h0000_0100);
        chk("t2_m_wr", 32'(m_wr), 1);
        chk("t2_m_wdata", m_wdata, 32'hCAFE_0001);
        chk("t2_m_wstrb", 32'(m_wstrb), 32'hF);
        chk("t2_data_addr_ok", 32'(data_addr_ok), 1);
        chk("t2_inst_addr_ok0", 32'(inst_addr_ok), 0);
        to_next();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        to_neg();
        chk("t2_m_addr_i", m_addr, 32'h0000_0200);
        chk("t2_inst_addr_ok", 32'(inst_addr_ok), 1);
        to_next();
        inst_req = 1'b0; m_addr_ok = 1'b0;
        m_data_ok = 1'b1; m_rdata = 32'h1111_1111;
        to_neg();
        chk("t2_r1_data_ok", 32'(data_data_ok), 1);
        chk("t2_r1_inst_ok", 32'(inst_data_ok), 0);
        chk("t2_r1_rdata", data_rdata, 32'h1111_1111);
        to_next();
        m_rdata = 32'h2222_2222;
        to_neg();
        chk("t2_r2_inst_ok", 32'(inst_data_ok), 1);
        chk("t2_r2_data_ok", 32'(data_data_ok), 0);
        chk("t2_r2_rdata", inst_rdata, 32'h2222_2222);
        to_next();
        m_data_ok = 1'b0;

        // Grant lock: data held while the bridge stalls, inst arrives late.
        data_req = 1'b1; data_addr = 32'h0000_0300;
        to_neg();
        chk("t3_c0_m_addr", m_addr, 32'h0000_0300);
        to_next();
        inst_req = 1'b1; inst_addr = 32'h0000_0400;
        for (int c = 1; c <= 2; c++) begin
            to_neg();
            chk("t3_lock_m_addr", m_addr, 32'h0000_0300);
            chk("t3_lock_inst_ok", 32'(inst_addr_ok), 0);
            to_next();
        end
        m_addr_ok = 1'b1;
        to_neg();
        chk("t3_data_addr_ok", 32'(data_addr_ok), 1);
        chk("t3_inst_addr_ok0", 32'(inst_addr_ok), 0);
        to_next();
        data_req = 1'b0;
        to_neg();
        chk("t3_inst_addr_ok", 32'(inst_addr_ok), 1);
        to_next();
        inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        to_neg();
        chk("t3_r1_data_ok", 32'(data_data_ok), 1);
        to_next();
        to_neg();
        chk("t3_r2_inst_ok", 32'(inst_data_ok), 1);
        to_next();
        m_data_ok = 1'b0;

        // Starvation bound: D D D I D D D I, responses drained one cycle behind.
        begin
            logic prev_d;
            prev_d = 1'b0;
            inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1;
            for (int k = 0; k < 8; k++) begin
                logic exp_d;
                exp_d = ((k % 4) != 3);
                m_data_ok = (k > 0);
                m_rdata = 32'(k);
                to_neg();
                chk("t4_grant_d", 32'(data_addr_ok), 32'(exp_d));
                chk("t4_grant_i", 32'(inst_addr_ok), 32'(!exp_d));
                if (k > 0) begin
                    chk("t4_resp_d", 32'(data_data_ok), 32'(prev_d));
                    chk("t4_resp_i", 32'(inst_data_ok), 32'(!prev_d));
                end
                prev_d = exp_d;
                to_next();
            end
            inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
            m_data_ok = 1'b1;
            to_neg();
            chk("t4_last_inst_ok", 32'(inst_data_ok), 1);
            to_next();
            m_data_ok = 1'b0;
        end

        // Full backpressure: four accepted, fifth waits until a pop has registered.
        inst_req = 1'b1; m_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk("t5_fill_addr_ok", 32'(inst_addr_ok), 1);
            to_next();
        end
        m_addr_ok = 1'b0;
        to_neg();
        chk("t5_full_m_req", 32'(m_req), 0);
        to_next();
        m_data_ok = 1'b1; m_rdata = 32'h0000_0055;
        to_neg();
        chk("t5_pop_same_cycle_m_req", 32'(m_req), 0);
        chk("t5_pop_inst_ok", 32'(inst_data_ok), 1);
        to_next();
        m_data_ok = 1'b0;
        to_neg();
        chk("t5_reassert_m_req", 32'(m_req), 1);
        to_next();
        m_addr_ok = 1'b1;
        to_neg();
        chk("t5_fifth_addr_ok", 32'(inst_addr_ok), 1);
        to_next();
        inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk("t5_drain_inst_ok", 32'(inst_data_ok), 1);
            to_next();
        end
        m_data_ok = 1'b0;

        // Response with nothing outstanding.
        m_data_ok = 1'b1;
        to_neg();
        chk("t6_err_inst_ok", 32'(inst_data_ok), 0);
        chk("t6_err_data_ok", 32'(data_data_ok), 0);
        chk("t6_err_before", 32'(resp_err), 0);
        to_next();
        m_data_ok = 1'b0;
        to_neg();
        chk("t6_resp_err", 32'(resp_err), 1);
        to_next();

        // Reset mid-burst with two data transactions outstanding.
        data_req = 1'b1; data_addr = 32'h0000_0500; m_addr_ok = 1'b1;
        to_next(); to_next();
        aresetn = 1'b0;
        #1;
        chk("t6_rst_m_req", 32'(m_req), 0);
        chk("t6_rst_m_addr", m_addr, 0);
        chk("t6_rst_data_addr_ok", 32'(data_addr_ok), 0);
        chk("t6_rst_resp_err", 32'(resp_err), 0);
        to_next();
        aresetn = 1'b1; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        to_neg();
        chk("t6_post_data_ok", 32'(data_data_ok), 0);
        chk("t6_post_inst_ok", 32'(inst_data_ok), 0);
        to_next();
        m_data_ok = 1'b0;
        to_neg();
        chk("t6_post_resp_err", 32'(resp_err), 1);
        to_next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
